// File: rtl/sdm2_bitstream_tx.sv
// sdm2_bitstream_tx
// Second-order digital sigma-delta modulator producing a 1-bit density-modulated
// stream from signed PCM samples. Each accepted sample stays active for OSR clk
// cycles. A one-entry pending register lets the next sample arrive during a frame.
//
// Ports
//   clk, reset_n          clock; asynchronous active-low reset
//   enable                run request (a running frame always completes)
//   sample_in/valid/ready PCM sample handshake
//   bit_out               bitstream, 1 = +FS, 0 = -FS
//   frame_strobe          1-cycle pulse in the first cycle of each new frame
//   busy                  state != IDLE
//   underrun/underrun_clr sticky "frame boundary without a sample" flag and its clear
//   digital_monitor_sel   test-point select
//   digital_monitor       registered test point
//
// state | meaning
// IDLE  | integrators held at 0, bit_out toggles (midscale pattern)
// PRIME | waiting for the first sample, integrators at 0, bit_out forced to 0
// RUN   | modulating; frames of OSR cycles, samples taken at frame boundaries
module sdm2_bitstream_tx #(
  parameter int OSR        = 256,
  parameter int CNT_WIDTH  = $clog2(OSR),
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  bit_out,
  output logic                  frame_strobe,
  output logic                  busy,
  output logic                  underrun,
  input  logic                  underrun_clr,
  input  logic [2:0]            digital_monitor_sel,
  output logic [ACC_WIDTH-1:0]  digital_monitor
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  // Two guard bits cover i + i + FS without wrapping before saturation.
  localparam int SUM_WIDTH = ACC_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(OSR - 1);
  localparam logic [ACC_WIDTH-1:0] FB_POS =
    {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] FB_NEG =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  frame_cnt;
  logic [DATA_WIDTH-1:0] active, pending;
  logic                  pending_valid;
  logic [ACC_WIDTH-1:0]  i1, i2, i1_n, i2_n, fb, active_ext;
  logic                  xfer, at_boundary;

  function automatic logic [SUM_WIDTH-1:0] sext2(input logic [ACC_WIDTH-1:0] x);
    return {{2{x[ACC_WIDTH-1]}}, x};
  endfunction

  // Clamp when the guard bits disagree with the accumulator sign bit.
  function automatic logic [ACC_WIDTH-1:0] sat(input logic [SUM_WIDTH-1:0] s);
    logic [2:0] top;
    top = s[SUM_WIDTH-1:ACC_WIDTH-1];
    if (top == 3'b000 || top == 3'b111) return s[ACC_WIDTH-1:0];
    else if (s[SUM_WIDTH-1])            return {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else                                return {1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // In PRIME a sample offered on the edge where enable falls is accepted and
  // then dropped, since the block returns to IDLE.
  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    case (state)
      IDLE:  if (enable) state_nxt = PRIME;
      PRIME: begin
        sample_ready = 1'b1;
        if (!enable)          state_nxt = IDLE;
        else if (sample_valid) state_nxt = RUN;
      end
      RUN: begin
        sample_ready = !pending_valid;
        if (frame_cnt == CNT_LAST && !enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign at_boundary = (state == RUN) && (frame_cnt == CNT_LAST);
  assign xfer        = sample_valid & sample_ready;

  always_comb begin
    fb         = bit_out ? FB_POS : FB_NEG;
    active_ext = {{(ACC_WIDTH-DATA_WIDTH){active[DATA_WIDTH-1]}}, active};
    i1_n       = sat(sext2(i1) + sext2(active_ext) - sext2(fb));
    i2_n       = sat(sext2(i2) + sext2(i1) - sext2(fb));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1            <= '0;
      i2            <= '0;
      bit_out       <= 1'b0;
      frame_cnt     <= '0;
      frame_strobe  <= 1'b0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      case (state)
        IDLE: begin
          i1            <= '0;
          i2            <= '0;
          bit_out       <= ~bit_out;
          frame_cnt     <= '0;
          pending_valid <= 1'b0;
        end
        PRIME: begin
          i1        <= '0;
          i2        <= '0;
          bit_out   <= 1'b0;
          frame_cnt <= '0;
          if (enable && xfer) begin
            active       <= sample_in;
            frame_strobe <= 1'b1;
          end
        end
        RUN: begin
          i1        <= i1_n;
          i2        <= i2_n;
          bit_out   <= ~i2_n[ACC_WIDTH-1];
          frame_cnt <= frame_cnt + CNT_WIDTH'(1);
          if (at_boundary) begin
            if (!enable) begin
              i1            <= '0;
              i2            <= '0;
              pending_valid <= 1'b0;
            end else begin
              frame_strobe <= 1'b1;
              if (pending_valid) begin
                active        <= pending;
                pending_valid <= 1'b0;
              end else if (xfer) begin
                active <= sample_in;
              end
            end
          end else if (xfer) begin
            pending       <= sample_in;
            pending_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A new underrun wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      underrun <= 1'b0;
    else if (at_boundary && enable && !pending_valid && !xfer)
      underrun <= 1'b1;
    else if (underrun_clr || (state == IDLE && enable))
      underrun <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digital_monitor <= '0;
    end else begin
      case (digital_monitor_sel)
        3'd0:    digital_monitor <= '0;
        3'd1:    digital_monitor <= active_ext;
        3'd2:    digital_monitor <= i1;
        3'd3:    digital_monitor <= i2;
        3'd4:    digital_monitor <= {{(ACC_WIDTH-CNT_WIDTH){1'b0}}, frame_cnt};
        3'd5:    digital_monitor <= {{(ACC_WIDTH-4){1'b0}}, state, pending_valid, underrun};
        3'd6:    digital_monitor <= {{(ACC_WIDTH-1){1'b0}}, bit_out};
        default: digital_monitor <= '1;
      endcase
    end
  end

endmodule

// File: tb/tb_sdm2_bitstream_tx.sv
// Testbench for sdm2_bitstream_tx: directed scenarios plus randomized sample
// traffic, checked by a frame-level reference model in a separate monitor.
module tb_sdm2_bitstream_tx;
  localparam int OSR  = 256;
  localparam int DW   = 16;
  localparam int AW   = 20;
  localparam int FS   = 32768;
  localparam int AMAX = 524287;
  localparam int AMIN = -524288;

  logic          clk = 1'b0;
  logic          reset_n, enable, sample_valid, underrun_clr;
  logic [DW-1:0] sample_in;
  logic [2:0]    digital_monitor_sel;
  logic          sample_ready, bit_out, frame_strobe, busy, underrun;
  logic [AW-1:0] digital_monitor;

  int checks = 0;
  int errors = 0;

  sdm2_bitstream_tx dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .bit_out(bit_out), .frame_strobe(frame_strobe), .busy(busy),
    .underrun(underrun), .underrun_clr(underrun_clr),
    .digital_monitor_sel(digital_monitor_sel), .digital_monitor(digital_monitor)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  function automatic int sat(input int x);
    return (x > AMAX) ? AMAX : ((x < AMIN) ? AMIN : x);
  endfunction

  function automatic logic [AW-1:0] sext(input logic [DW-1:0] a);
    return {{(AW-DW){a[DW-1]}}, a};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] acc_q[$];   // accepted samples not yet active
  bit            bq[$];      // expected bit_out sequence
  int            mi1 = 0, mi2 = 0;
  bit            mb = 1'b0;
  logic [DW-1:0] act = '0;
  int            cyc = -1;   // model frame position, -1 when not running
  bit            en_b, m_ur, act_chk, prev_en, idle_exp;
  logic [2:0]    act_sel, prev_sel;
  int            idle_chk = 0;
  bit            start, first, stopped, xfer, exp_b;

  // One frame of the modulator equations, in plain integer arithmetic.
  function automatic void run_frame();
    int fb, n1, n2;
    for (int k = 0; k < OSR; k++) begin
      fb  = mb ? FS : -FS;
      n1  = sat(mi1 + int'($signed(act)) - fb);
      n2  = sat(mi2 + mi1 - fb);
      mi1 = n1;
      mi2 = n2;
      mb  = (n2 >= 0);
      bq.push_back(mb);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      cyc = -1; bq.delete(); acc_q.delete();
      m_ur = 0; act_chk = 0; idle_chk = 0; prev_en = 0;
      prev_sel = digital_monitor_sel;
    end else begin
      start = 0; first = 0; stopped = 0;
      check("underrun", underrun, m_ur);
      if (act_chk && digital_monitor_sel == 3'd1 && act_sel == 3'd1)
        check("active_mon", digital_monitor, sext(act));
      act_chk = 0;
      if (cyc >= 0) begin
        cyc++;
        if (cyc == OSR) begin
          check("strobe_at_boundary", frame_strobe, en_b);
          if (frame_strobe) start = 1;
          else begin
            cyc = -1; stopped = 1; acc_q.delete();
            check("busy_after_stop", busy, 0);
            check("ready_after_stop", sample_ready, 0);
          end
        end else begin
          check("strobe_mid_frame", frame_strobe, 0);
        end
      end else if (frame_strobe) begin
        start = 1; first = 1;
      end
      if (start) begin
        cyc = 0;
        if (first) begin
          check("prime_accept_count", acc_q.size(), 1);
          bq.delete(); bq.push_back(1'b0);
          mi1 = 0; mi2 = 0; mb = 1'b0;
        end
        if (acc_q.size() > 0) act = acc_q.pop_front();
        run_frame();
        act_chk = 1;
        act_sel = digital_monitor_sel;
      end
      if (cyc >= 0) begin
        check("busy_run", busy, 1);
        check("ready_run", sample_ready, acc_q.size() == 0);
        if (cyc >= 1 && digital_monitor_sel == 3'd4 && prev_sel == 3'd4)
          check("frame_cnt_mon", digital_monitor, cyc - 1);
      end
      if (bq.size() > 0) begin
        exp_b = bq.pop_front();
        check("bit_out", bit_out, exp_b);
        if (stopped) begin idle_exp = exp_b; idle_chk = 8; end
      end else if (idle_chk > 0 && cyc < 0) begin
        if (prev_en) idle_chk = 0;
        else begin
          idle_exp = ~idle_exp;
          check("idle_toggle", bit_out, idle_exp);
          idle_chk--;
        end
      end
      // model updates for the coming clock edge
      xfer = sample_valid && sample_ready;
      if (cyc == OSR - 1) en_b = enable;
      if (cyc == OSR - 1 && enable && acc_q.size() == 0 && !xfer) m_ur = 1;
      else if (underrun_clr || (cyc < 0 && enable)) m_ur = 0;
      if (xfer) acc_q.push_back(sample_in);
      prev_en  = enable;
      prev_sel = digital_monitor_sel;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_strobe(input string name);
    int n = 0;
    @(negedge clk);
    while (!frame_strobe && n < 700) begin @(negedge clk); n++; end
    if (!frame_strobe) check({name, "_timeout"}, frame_strobe, 1);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int k = 0; k < n; k++) begin @(negedge clk); ones += int'(bit_out); end
  endtask

  task automatic mon_check(input logic [2:0] sel, input longint exp, input string name);
    digital_monitor_sel = sel;
    @(posedge clk); @(negedge clk);
    check(name, digital_monitor, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, sample_ready, 0);
    check({tag, "_bit_out"}, bit_out, 0);
    check({tag, "_strobe"}, frame_strobe, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_monitor"}, digital_monitor, 0);
  endtask

  initial begin
    int ones;
    reset_n = 0; enable = 0; sample_valid = 0; sample_in = '0;
    underrun_clr = 0; digital_monitor_sel = 3'd1;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    check("idle_ready", sample_ready, 0);
    check("idle_busy", busy, 0);
    mon_check(3'd7, (1 << AW) - 1, "mon_sel7");
    mon_check(3'd0, 0, "mon_sel0");
    digital_monitor_sel = 3'd1;

    // zero input, sample offered continuously
    sample_in = 16'h0000; sample_valid = 1; enable = 1;
    repeat (3) wait_strobe("t1");
    count_ones(OSR, ones);
    check_range("t1_ones_per_frame", ones, 126, 130);

    // +0.5 FS
    sample_in = 16'h4000;
    repeat (3) wait_strobe("t2");
    count_ones(4 * OSR, ones);
    check_range("t2_ones_4frames", ones, 758, 778);

    // withhold samples -> underrun, clear, then a transfer on the boundary edge
    sample_valid = 0;
    repeat (3) wait_strobe("t4");
    check("t4_underrun_set", underrun, 1);
    repeat (10) @(posedge clk);
    #1 underrun_clr = 1;
    @(posedge clk); #1 underrun_clr = 0;
    repeat (244) @(posedge clk);
    #1 sample_valid = 1; sample_in = 16'hD123;
    @(posedge clk); #1 sample_valid = 0;
    @(negedge clk);
    check("t4_bypass_no_underrun", underrun, 0);
    check("t4_bypass_strobe", frame_strobe, 1);

    // randomized traffic
    digital_monitor_sel = 3'd4;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (c == 1500) digital_monitor_sel = 3'd1;
      sample_valid = ($urandom_range(0, 199) == 0);
      sample_in    = DW'($urandom_range(0, 45874) - 22937);
      underrun_clr = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1 sample_valid = 0; underrun_clr = 0;

    // drop enable mid-frame
    wait_strobe("t5");
    repeat (100) @(posedge clk);
    #1 enable = 0;
    repeat (170) @(negedge clk);
    check("t5_busy", busy, 0);
    mon_check(3'd2, 0, "t5_i1");
    mon_check(3'd3, 0, "t5_i2");

    // reset while a sample is pending
    digital_monitor_sel = 3'd1;
    sample_in = 16'h1234; sample_valid = 1; enable = 1;
    wait_strobe("t6");
    @(posedge clk); #1 sample_valid = 0;
    mon_check(3'd5, 10, "t6_status_run_pending");
    @(posedge clk); #2 reset_n = 0; enable = 0;
    #1 check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_busy", busy, 0);
      check("post_reset_ready", sample_ready, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
